// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU B-operand definitions: select width, operand mode
//               codes and skid-buffer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int SEL_W = 3;

    // alu_srcB operand modes
    localparam logic [SEL_W-1:0] SRCB_REG    = 3'b000;
    localparam logic [SEL_W-1:0] SRCB_ONE    = 3'b001;
    localparam logic [SEL_W-1:0] SRCB_SEXT6  = 3'b010;
    localparam logic [SEL_W-1:0] SRCB_ZEXT8  = 3'b011;
    localparam logic [SEL_W-1:0] SRCB_SEXT12 = 3'b100;
    localparam logic [SEL_W-1:0] SRCB_BR     = 3'b101;
    localparam logic [SEL_W-1:0] SRCB_LUI    = 3'b110;
    localparam logic [SEL_W-1:0] SRCB_ZERO   = 3'b111;

    // Output skid-buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_b_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_b_operand_stage_if
// Description : Operand request/response bundle for the ALU B-operand stage.
//               master = decode side plus ALU consumer, slave = the stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_b_operand_stage_if #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 12,
    parameter int SEL_W  = 3
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  alu_srcB;
    logic [IMM_W-1:0]  ir_imm;
    logic [DATA_W-1:0] B;
    logic              ex_fwd_vld;
    logic [DATA_W-1:0] ex_fwd_data;
    logic              wb_fwd_vld;
    logic [DATA_W-1:0] wb_fwd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_B;
    logic [SEL_W-1:0]  alu_B_mode;

    modport master (
        output flush, in_valid, alu_srcB, ir_imm, B,
               ex_fwd_vld, ex_fwd_data, wb_fwd_vld, wb_fwd_data, out_ready,
        input  in_ready, out_valid, alu_B, alu_B_mode
    );

    modport slave (
        input  flush, in_valid, alu_srcB, ir_imm, B,
               ex_fwd_vld, ex_fwd_data, wb_fwd_vld, wb_fwd_data, out_ready,
        output in_ready, out_valid, alu_B, alu_B_mode
    );

endinterface : alu_b_operand_stage_if
`default_nettype wire

// File: rtl/alu_b_select.sv
`default_nettype none
// ============================================================================
// Module      : alu_b_select
// Description : Combinational B-operand mux: register path with EX/WB
//               forwarding, constants and extended/shifted immediates.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_b_select #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 12,
    parameter int SEL_W  = 3
) (
    input  wire logic [SEL_W-1:0]  alu_srcB,
    input  wire logic [IMM_W-1:0]  ir_imm,
    input  wire logic [DATA_W-1:0] B,
    input  wire logic              ex_fwd_vld,
    input  wire logic [DATA_W-1:0] ex_fwd_data,
    input  wire logic              wb_fwd_vld,
    input  wire logic [DATA_W-1:0] wb_fwd_data,
    output logic      [DATA_W-1:0] operand
);
    import alu_pkg::*;

    logic [DATA_W-1:0] w_sext_imm;
    logic [15:0]       w_lui16;

    // Full-width sign extension is shared by the SEXT12 and branch modes
    assign w_sext_imm = {{(DATA_W-IMM_W){ir_imm[IMM_W-1]}}, ir_imm};
    // LUI pattern is defined on 16 bits; resized (zero-extend or truncate) below
    assign w_lui16    = {ir_imm[7:0], 8'h00};

    // Mode decode; EX forward has priority over WB since it is the younger result
    always_comb begin
        operand = '0;
        case (alu_srcB)
            SRCB_REG: begin
                if (ex_fwd_vld)      operand = ex_fwd_data;
                else if (wb_fwd_vld) operand = wb_fwd_data;
                else                 operand = B;
            end
            SRCB_ONE:    operand = {{(DATA_W-1){1'b0}}, 1'b1};
            SRCB_SEXT6:  operand = {{(DATA_W-6){ir_imm[5]}}, ir_imm[5:0]};
            SRCB_ZEXT8:  operand = {{(DATA_W-8){1'b0}}, ir_imm[7:0]};
            SRCB_SEXT12: operand = w_sext_imm;
            SRCB_BR:     operand = {w_sext_imm[DATA_W-2:0], 1'b0};
            SRCB_LUI:    operand = DATA_W'(w_lui16);
            SRCB_ZERO:   operand = '0;
            default:     operand = '0;
        endcase
    end

endmodule : alu_b_select
`default_nettype wire

// File: rtl/alu_b_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_b_operand_stage
// Description : Registered ALU B-operand stage. Selects the operand, then
//               holds it in a 2-entry skid buffer so in_ready is a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_b_operand_stage #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 12,
    parameter int SEL_W  = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_b_operand_stage_if.slave bus
);
    import alu_pkg::*;

    buf_state_t        r_state;
    buf_state_t        w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_mode;
    logic [DATA_W-1:0] r_skid_data;
    logic [SEL_W-1:0]  r_skid_mode;

    logic [DATA_W-1:0] w_sel_data;
    logic              w_push;
    logic              w_pop;
    logic              w_load_out;
    logic              w_load_skid;
    logic              w_skid_to_out;

    alu_b_select #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .SEL_W  (SEL_W)
    ) u_select (
        .alu_srcB    (bus.alu_srcB),
        .ir_imm      (bus.ir_imm),
        .B           (bus.B),
        .ex_fwd_vld  (bus.ex_fwd_vld),
        .ex_fwd_data (bus.ex_fwd_data),
        .wb_fwd_vld  (bus.wb_fwd_vld),
        .wb_fwd_data (bus.wb_fwd_data),
        .operand     (w_sel_data)
    );

    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = (r_state != ST_EMPTY) && bus.out_ready;

    // Buffer next-state and datapath steering; flush overrides every transfer
    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ST_ONE;
                        w_load_out  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_load_out  = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt   = ST_ONE;
                        w_skid_to_out = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State register; in_ready is precomputed from the next state so it is a flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Output and skid registers; output only changes on load so it holds under stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_mode  <= '0;
            r_skid_data <= '0;
            r_skid_mode <= '0;
        end else begin
            if (w_load_out) begin
                r_out_data <= w_sel_data;
                r_out_mode <= bus.alu_srcB;
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
                r_out_mode <= r_skid_mode;
            end
            if (w_load_skid) begin
                r_skid_data <= w_sel_data;
                r_skid_mode <= bus.alu_srcB;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = (r_state != ST_EMPTY);
    assign bus.alu_B      = r_out_data;
    assign bus.alu_B_mode = r_out_mode;

endmodule : alu_b_operand_stage
`default_nettype wire
